// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: payload widths, field offsets, bubble
// patterns and the handshake stage state encoding.
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0020;

  localparam int INST_W       = 32;
  localparam int PC_W         = 9;
  localparam int IDEX_CTRL_W  = 10;
  localparam int EXMEM_CTRL_W = 6;
  localparam int MEMWB_CTRL_W = 3;

  // Payload layout, LSB first: inst, then pc_4, then control.
  localparam int INST_LSB = 0;
  localparam int PC_LSB   = INST_LSB + INST_W;
  localparam int CTRL_LSB = PC_LSB + PC_W;

  localparam int IFID_W  = PC_W + INST_W;
  localparam int IDEX_W  = IDEX_CTRL_W + PC_W + INST_W;
  localparam int EXMEM_W = EXMEM_CTRL_W + PC_W + INST_W;
  localparam int MEMWB_W = MEMWB_CTRL_W + PC_W + INST_W;

  localparam logic [IFID_W-1:0]  IFID_BUBBLE  = {{PC_W{1'b0}}, NOP_INST};
  localparam logic [IDEX_W-1:0]  IDEX_BUBBLE  = {{IDEX_CTRL_W{1'b0}}, {PC_W{1'b0}}, NOP_INST};
  localparam logic [EXMEM_W-1:0] EXMEM_BUBBLE = {{EXMEM_CTRL_W{1'b0}}, {PC_W{1'b0}}, NOP_INST};
  localparam logic [MEMWB_W-1:0] MEMWB_BUBBLE = {{MEMWB_CTRL_W{1'b0}}, {PC_W{1'b0}}, NOP_INST};

  // Encoding is {main valid, skid valid}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } stage_st_e;

  function automatic logic [EXMEM_W-1:0] exmem_pack(
    input logic [EXMEM_CTRL_W-1:0] ctrl,
    input logic [PC_W-1:0]         pc,
    input logic [INST_W-1:0]       inst
  );
    return {ctrl, pc, inst};
  endfunction

  function automatic logic [INST_W-1:0] exmem_inst(input logic [EXMEM_W-1:0] payload);
    return payload[INST_LSB +: INST_W];
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around one pipeline stage register.
// master = upstream/downstream environment, slave = the stage itself.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush-to-bubble and a saturating downstream-stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = EXMEM_W,
  parameter logic [DATA_W-1:0] BUBBLE = EXMEM_BUBBLE,
  parameter int                SKID   = 1,
  parameter int                CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cnt_clr,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_st_e         state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_v_s;
  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;

  assign main_v_s   = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign in_fire_s  = bus.in_valid & in_ready_s;
  assign out_fire_s = main_v_s & bus.out_ready;

  // Next state and payload: flush first, then the FIFO transfer rules.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_d  = bus.in_data;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (out_fire_s && in_fire_s) begin
            main_d = bus.in_data;
          end else if (out_fire_s) begin
            main_d  = BUBBLE;
            state_d = ST_EMPTY;
          end else if (in_fire_s && (SKID != 0)) begin
            skid_d  = bus.in_data;
            state_d = ST_FULL;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic in_ready_q;
    logic in_ready_d;

    // Ready for the next cycle unless the skid slot will be occupied.
    always_comb begin
      in_ready_d = (state_d != ST_FULL);
    end

    // Registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= in_ready_d;
      end
    end

    assign in_ready_s = in_ready_q;
  end else begin : g_noskid
    assign in_ready_s = bus.out_ready | ~main_v_s;
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = main_v_s;
  assign bus.out_data  = main_q;

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (main_v_s & ~bus.out_ready),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/CNT_W=4 instance and a SKID=0 instance
// share stimulus; each is checked against a queue-based reference model,
// and the SKID=1 instance also against a hand-derived vector table.
module tb_pipe_stage_reg;

  localparam logic [46:0] BUB = 47'h20;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       cnt_clr;
  logic [3:0] cnt_s1;
  logic [15:0] cnt_s0;

  pipe_stage_reg_if #(.DATA_W(47)) if_s1 ();
  pipe_stage_reg_if #(.DATA_W(47)) if_s0 ();

  pipe_stage_reg #(.DATA_W(47), .BUBBLE(47'h20), .SKID(1), .CNT_W(4)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .bus(if_s1), .stall_cnt(cnt_s1)
  );

  pipe_stage_reg #(.DATA_W(47), .BUBBLE(47'h20), .SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr),
    .bus(if_s0), .stall_cnt(cnt_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: stage contents as a FIFO queue, counters as integers.
  logic [46:0] q1[$];
  logic [46:0] q0[$];
  int cnt1 = 0;
  int cnt0 = 0;

  typedef struct {
    logic        iv;
    logic [46:0] id;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic        ev;
    logic [46:0] ed;
    logic        er;
    logic [3:0]  ec;
  } vec_t;

  vec_t tv[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs against model, advance model.
  task automatic step(input logic iv, input logic [46:0] id, input logic ordy,
                      input logic fl, input logic clr);
    logic v1, r1, v0, r0;
    logic [46:0] d1, d0;
    @(negedge clk);
    if_s1.in_valid = iv; if_s1.in_data = id; if_s1.out_ready = ordy;
    if_s0.in_valid = iv; if_s0.in_data = id; if_s0.out_ready = ordy;
    flush = fl; cnt_clr = clr;
    #1;
    v1 = (q1.size() > 0);
    r1 = (q1.size() < 2);
    d1 = BUB;
    if (v1) d1 = q1[0];
    v0 = (q0.size() > 0);
    r0 = ordy || (q0.size() == 0);
    d0 = BUB;
    if (v0) d0 = q0[0];
    chk("s1_out_valid", {63'd0, if_s1.out_valid}, {63'd0, v1});
    chk("s1_out_data", {17'd0, if_s1.out_data}, {17'd0, d1});
    chk("s1_in_ready", {63'd0, if_s1.in_ready}, {63'd0, r1});
    chk("s1_stall_cnt", {60'd0, cnt_s1}, 64'(cnt1));
    chk("s0_out_valid", {63'd0, if_s0.out_valid}, {63'd0, v0});
    chk("s0_out_data", {17'd0, if_s0.out_data}, {17'd0, d0});
    chk("s0_in_ready", {63'd0, if_s0.in_ready}, {63'd0, r0});
    chk("s0_stall_cnt", {48'd0, cnt_s0}, 64'(cnt0));
    if (clr) cnt1 = 0; else if (v1 && !ordy && cnt1 < 15) cnt1++;
    if (clr) cnt0 = 0; else if (v0 && !ordy && cnt0 < 65535) cnt0++;
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (v1 && ordy) void'(q1.pop_front());
      if (iv && r1) q1.push_back(id);
      if (v0 && ordy) void'(q0.pop_front());
      if (iv && r0) q0.push_back(id);
    end
  endtask

  initial begin
    // iv, id, ordy, fl, clr | exp valid, data, in_ready, stall_cnt (SKID=1, CNT_W=4)
    tv[0]  = '{1'b1, 47'h1, 1'b1, 1'b0, 1'b0, 1'b0, BUB,   1'b1, 4'd0};
    tv[1]  = '{1'b1, 47'h2, 1'b1, 1'b0, 1'b0, 1'b1, 47'h1, 1'b1, 4'd0};
    tv[2]  = '{1'b1, 47'h3, 1'b1, 1'b0, 1'b0, 1'b1, 47'h2, 1'b1, 4'd0};
    tv[3]  = '{1'b1, 47'h4, 1'b1, 1'b0, 1'b0, 1'b1, 47'h3, 1'b1, 4'd0};
    tv[4]  = '{1'b0, 47'h0, 1'b1, 1'b0, 1'b0, 1'b1, 47'h4, 1'b1, 4'd0};
    tv[5]  = '{1'b0, 47'h0, 1'b1, 1'b0, 1'b0, 1'b0, BUB,   1'b1, 4'd0};
    tv[6]  = '{1'b1, 47'hA, 1'b0, 1'b0, 1'b0, 1'b0, BUB,   1'b1, 4'd0};
    tv[7]  = '{1'b1, 47'hB, 1'b0, 1'b0, 1'b0, 1'b1, 47'hA, 1'b1, 4'd0};
    tv[8]  = '{1'b1, 47'hC, 1'b0, 1'b0, 1'b0, 1'b1, 47'hA, 1'b0, 4'd1};
    tv[9]  = '{1'b1, 47'hC, 1'b1, 1'b0, 1'b0, 1'b1, 47'hA, 1'b0, 4'd2};
    tv[10] = '{1'b1, 47'hC, 1'b1, 1'b0, 1'b0, 1'b1, 47'hB, 1'b1, 4'd2};
    tv[11] = '{1'b0, 47'h0, 1'b1, 1'b0, 1'b0, 1'b1, 47'hC, 1'b1, 4'd2};
    tv[12] = '{1'b0, 47'h0, 1'b1, 1'b0, 1'b0, 1'b0, BUB,   1'b1, 4'd2};
    tv[13] = '{1'b1, 47'hE, 1'b0, 1'b0, 1'b0, 1'b0, BUB,   1'b1, 4'd2};
    tv[14] = '{1'b1, 47'hF, 1'b0, 1'b0, 1'b0, 1'b1, 47'hE, 1'b1, 4'd2};
    tv[15] = '{1'b0, 47'h0, 1'b0, 1'b1, 1'b0, 1'b1, 47'hE, 1'b0, 4'd3};
    tv[16] = '{1'b1, 47'hD, 1'b1, 1'b0, 1'b0, 1'b0, BUB,   1'b1, 4'd4};
    tv[17] = '{1'b0, 47'h0, 1'b1, 1'b0, 1'b0, 1'b1, 47'hD, 1'b1, 4'd4};
    tv[18] = '{1'b0, 47'h0, 1'b1, 1'b0, 1'b1, 1'b0, BUB,   1'b1, 4'd4};
    tv[19] = '{1'b0, 47'h0, 1'b1, 1'b0, 1'b0, 1'b0, BUB,   1'b1, 4'd0};

    rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    if_s1.in_valid = 1'b0; if_s1.in_data = 47'h0; if_s1.out_ready = 1'b0;
    if_s0.in_valid = 1'b0; if_s0.in_data = 47'h0; if_s0.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s1_out_valid", {63'd0, if_s1.out_valid}, 64'd0);
    chk("rst_s1_out_data", {17'd0, if_s1.out_data}, 64'h20);
    chk("rst_s1_in_ready", {63'd0, if_s1.in_ready}, 64'd1);
    chk("rst_s1_stall_cnt", {60'd0, cnt_s1}, 64'd0);
    chk("rst_s0_out_data", {17'd0, if_s0.out_data}, 64'h20);
    rst_n = 1'b1;

    // Directed table: streaming, backpressure, flush while full, clear.
    for (int i = 0; i < 20; i++) begin
      step(tv[i].iv, tv[i].id, tv[i].ordy, tv[i].fl, tv[i].clr);
      chk($sformatf("tv%0d_valid", i), {63'd0, if_s1.out_valid}, {63'd0, tv[i].ev});
      chk($sformatf("tv%0d_data", i), {17'd0, if_s1.out_data}, {17'd0, tv[i].ed});
      chk($sformatf("tv%0d_ready", i), {63'd0, if_s1.in_ready}, {63'd0, tv[i].er});
      chk($sformatf("tv%0d_cnt", i), {60'd0, cnt_s1}, {60'd0, tv[i].ec});
    end

    // Saturation of the 4-bit counter, then clear.
    step(1'b1, 47'h5A5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 47'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 47'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt15", {60'd0, cnt_s1}, 64'd15);
    step(1'b0, 47'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 47'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_clr0", {60'd0, cnt_s1}, 64'd0);
    step(1'b0, 47'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 47'h0, 1'b1, 1'b0, 1'b0);

    // SKID=0: combinational in_ready follows out_ready while main is valid.
    step(1'b1, 47'h1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 47'h2222, 1'b0, 1'b0, 1'b0);
    chk("s0_rdy_low", {63'd0, if_s0.in_ready}, 64'd0);
    step(1'b1, 47'h2222, 1'b1, 1'b0, 1'b0);
    chk("s0_rdy_same_cycle", {63'd0, if_s0.in_ready}, 64'd1);
    chk("s0_old_data", {17'd0, if_s0.out_data}, 64'h1111);
    step(1'b0, 47'h0, 1'b1, 1'b0, 1'b0);
    chk("s0_new_data", {17'd0, if_s0.out_data}, 64'h2222);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), {15'($urandom), 32'($urandom)},
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset while holding traffic.
    step(1'b1, 47'h7777, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    if_s1.in_valid = 1'b0; if_s0.in_valid = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s1_valid", {63'd0, if_s1.out_valid}, 64'd0);
    chk("mid_rst_s1_data", {17'd0, if_s1.out_data}, 64'h20);
    chk("mid_rst_s1_ready", {63'd0, if_s1.in_ready}, 64'd1);
    chk("mid_rst_s0_cnt", {48'd0, cnt_s0}, 64'd0);
    q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1'($urandom_range(0, 1)), {15'($urandom), 32'($urandom)},
           1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core. It replaces the fixed-layout stall/flush registers with a valid/ready handshake stage that carries an arbitrary-width payload. It has an optional two-entry skid buffer so that in_ready is registered. A flush forces the stage to a bubble whose payload is a configurable NOP pattern. A saturating counter records stall cycles for performance analysis.

Parameters:
DATA_W, 47, payload width in bits (EX/MEM default: 6 control + 9 pc_4 + 32 inst).
BUBBLE, {15'b0, 32'h0000_0020}, payload value presented whenever the stage holds no valid entry.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  discard all held entries; stage becomes empty next cycle
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept a payload this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  stage presents a valid payload
out_ready  in  1  downstream accepts (low = downstream stall)
out_data  out  DATA_W  payload to downstream; equals BUBBLE when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset values: main_v=0, skid_v=0, main_data=BUBBLE, skid_data=BUBBLE, stall_cnt=0, in_ready=1.
- Invariant: main_v=0 implies main_data==BUBBLE. out_data=main_data and out_valid=main_v, both straight from flops.
- State machine, SKID=1, encoded {main_v, skid_v}:
  - EMPTY (0,0): in_fire loads main_data<=in_data and moves to BUSY.
  - BUSY (1,0), out_fire & in_fire: main<=in, stays in BUSY.
  - BUSY, out_fire only: main_data<=BUBBLE, moves to EMPTY.
  - BUSY, in_fire only: skid<=in, moves to FULL.
  - BUSY, neither: hold.
  - FULL (1,1): in_ready=0. out_fire: main<=skid, skid_data<=BUBBLE, moves to BUSY. Otherwise hold.
  - (0,1) is illegal and unreachable.
  - in_ready is registered: next in_ready = !next_skid_v.
- SKID=0: no skid register. in_ready = out_ready | ~main_v (combinational).
  - in_fire loads main.
  - out_fire without in_fire goes to EMPTY with BUBBLE.
- Latency: one cycle from in_fire to out_valid. A full-throughput stream sustains 1 transfer/cycle in both modes.
- Ordering: strictly FIFO. The skid entry always leaves after the main entry.
- flush (highest priority, synchronous):
  - Next cycle main_v=skid_v=0, both data regs=BUBBLE, in_ready=1.
  - Any in_fire or out_fire in the flush cycle is still a completed handshake for the other side, but the accepted input is discarded.
  - flush together with out_ready=0 still empties the stage.
- stall_cnt:
  - Increments when out_valid & ~out_ready and it is below 2^CNT_W-1; holds at the maximum.
  - cnt_clr has priority over increment and loads 0.
  - flush does not affect stall_cnt.
- Reset mid-operation: asynchronous return to reset values; held payloads are lost.
- in_data is ignored when in_valid=0. No X from in_data may reach out_data while out_valid=0.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INST = 32'h0000_0020.
  - Per-stage payload widths (IFID_W, IDEX_W, EXMEM_W, MEMWB_W).
  - Per-stage BUBBLE constants built from NOP_INST with zeroed control and pc fields.
  - Field-offset localparams used to pack and unpack control/pc/inst.
- One sub-module: pipe_sat_cnt (CNT_W saturating counter with clear and enable), instantiated for stall_cnt.

Test Plan:
1. Reset with rst_n=0, then release. Expect out_valid=0, out_data=47'h20, in_ready=1, stall_cnt=0.
2. SKID=1 streaming: in_valid=1 with data 1,2,3,4 and out_ready=1 throughout. Expect out_data 1,2,3,4 on the following four cycles, one cycle after each input, with no bubbles.
3. Backpressure, SKID=1: send A then B while out_ready=0.
   - Expect FULL state with in_ready=0 on the cycle after B; C is held off.
   - Raise out_ready; expect A, B, C in order.
   - stall_cnt equals the number of cycles out_valid=1 and out_ready=0.
4. Flush while FULL with out_ready=0. Next cycle expect out_valid=0, out_data=BUBBLE and in_ready=1. A subsequent D emerges alone.
5. Saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles. Expect stall_cnt=15, then cnt_clr gives 0 the next cycle.
6. SKID=0 mode: out_ready=0 with main valid. Expect in_ready=0 combinationally; it goes high in the same cycle out_ready rises, and new data replaces old after one cycle.
